// File: rtl/fifo_1w_2r_pkg.sv
// Shared defaults and pop-type encoding for the 1-write/2-read and 2-write/1-read FIFOs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_1w_2r_pkg;

  localparam int DEF_DATA_WIDTH    = 65;
  localparam int DEF_ADDRESS_WIDTH = 2;

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

  function automatic logic [1:0] pop_words(pop_e p);
    return logic'(p == POP_TWO) ? 2'd2 : (logic'(p == POP_ONE) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/fifo_1w_2r_if.sv
// Write/read/status bundle of the 1-write/2-read FIFO; master drives requests, slave is the FIFO.
// Latency: n/a (wiring only).
// Backpressure: Full_out refuses writes; Pair_avail/Empty_out gate pair and drain reads.
interface fifo_1w_2r_if
  import fifo_1w_2r_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  stall;
  logic [DATA_WIDTH-1:0] Data_in;
  logic                  WriteEn_in;
  logic                  Full_out;
  logic                  ReadEn_in;
  logic                  Drain_in;
  logic [DATA_WIDTH-1:0] Data_out_1;
  logic [DATA_WIDTH-1:0] Data_out_2;
  logic                  Data_valid_1;
  logic                  Data_valid_2;
  logic                  Empty_out;
  logic                  Pair_avail;

  modport master (
    output stall, Data_in, WriteEn_in, ReadEn_in, Drain_in,
    input  Full_out, Data_out_1, Data_out_2, Data_valid_1, Data_valid_2,
           Empty_out, Pair_avail
  );

  modport slave (
    input  stall, Data_in, WriteEn_in, ReadEn_in, Drain_in,
    output Full_out, Data_out_1, Data_out_2, Data_valid_1, Data_valid_2,
           Empty_out, Pair_avail
  );
endinterface

// File: rtl/fifo_rptr_2step.sv
// Read pointer advancing by 0, 1 or 2 entries with power-of-two wrap; also exposes rd_ptr+1.
// Latency: pointer moves on the edge that accepts the pop.
// Backpressure: none; caller only requests pops that the occupancy allows.
module fifo_rptr_2step
  import fifo_1w_2r_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  pop_e                     pop,
  output logic [ADDRESS_WIDTH-1:0] rd_ptr,
  output logic [ADDRESS_WIDTH-1:0] rd_ptr_p1
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr <= '0;
    end else begin
      unique case (pop)
        POP_ONE: rd_ptr <= rd_ptr + ADDRESS_WIDTH'(1);
        POP_TWO: rd_ptr <= rd_ptr + ADDRESS_WIDTH'(2);
        default: rd_ptr <= rd_ptr;
      endcase
    end
  end

  assign rd_ptr_p1 = rd_ptr + ADDRESS_WIDTH'(1);

endmodule

// File: rtl/fifo_1w_2r.sv
// Single-clock FIFO: one word in per cycle, an ordered pair (or a drained single) out per cycle.
// Latency: popped data registered, valid one cycle after the accepting edge.
// Backpressure: writes dropped when full or stalled; pops need count>=2 (or 1 with Drain_in).
module fifo_1w_2r
  import fifo_1w_2r_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input logic             Clk,
  input logic             Reset_n,
  fifo_1w_2r_if.slave     bus
);

  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW         = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_p1;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_nxt;
  logic                     wr_acc;
  pop_e                     pop;

  assign bus.Full_out   = (count == CW'(FIFO_DEPTH));
  assign bus.Empty_out  = (count == '0);
  assign bus.Pair_avail = (count >= CW'(2));

  assign wr_acc = bus.WriteEn_in & ~bus.Full_out & ~bus.stall;

  // Pop decision uses the count before this cycle's write: a word is never popped the cycle it lands.
  always_comb begin
    pop = POP_NONE;
    if (bus.ReadEn_in && !bus.stall) begin
      if (count >= CW'(2)) begin
        pop = POP_TWO;
      end else if (count == CW'(1) && bus.Drain_in) begin
        pop = POP_ONE;
      end
    end
  end

  assign count_nxt = count + CW'(wr_acc) - CW'(pop_words(pop));

  fifo_rptr_2step #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_rptr (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .pop       (pop),
    .rd_ptr    (rd_ptr),
    .rd_ptr_p1 (rd_ptr_p1)
  );

  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.Data_in;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
      end
      count <= count_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.Data_out_1   <= '0;
      bus.Data_out_2   <= '0;
      bus.Data_valid_1 <= 1'b0;
      bus.Data_valid_2 <= 1'b0;
    end else begin
      bus.Data_valid_1 <= (pop != POP_NONE);
      bus.Data_valid_2 <= (pop == POP_TWO);
      if (pop != POP_NONE) begin
        bus.Data_out_1 <= mem[rd_ptr];
      end
      // Lane 2 keeps its old value on a single-entry drain.
      if (pop == POP_TWO) begin
        bus.Data_out_2 <= mem[rd_ptr_p1];
      end
    end
  end

endmodule

// File: tb/tb_fifo_1w_2r.sv
// Directed bench for fifo_1w_2r: queue model checked every falling edge plus literal pins.
module tb_fifo_1w_2r;
  import fifo_1w_2r_pkg::*;

  localparam int DW    = 65;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  int   checks = 0;
  int   errs   = 0;

  fifo_1w_2r_if #(.DATA_WIDTH(DW)) bus ();

  fifo_1w_2r #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // Reference model: a plain queue of words plus the last popped outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_d1 = '0;
  logic [DW-1:0] m_d2 = '0;
  logic          m_v1 = 1'b0;
  logic          m_v2 = 1'b0;
  pop_e          m_pop;
  int            m_n;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q.delete();
      m_d1 = '0; m_d2 = '0; m_v1 = 1'b0; m_v2 = 1'b0;
    end else begin
      m_n   = q.size();
      m_pop = POP_NONE;
      if (bus.ReadEn_in && !bus.stall) begin
        if (m_n >= 2) m_pop = POP_TWO;
        else if (m_n == 1 && bus.Drain_in) m_pop = POP_ONE;
      end
      m_v1 = (m_pop != POP_NONE);
      m_v2 = (m_pop == POP_TWO);
      if (m_pop != POP_NONE) m_d1 = q.pop_front();
      if (m_pop == POP_TWO)  m_d2 = q.pop_front();
      if (bus.WriteEn_in && !bus.stall && m_n < DEPTH) q.push_back(bus.Data_in);
    end
  end

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if ($time > 5) begin
      check("m_full",  DW'(bus.Full_out),     DW'(q.size() == DEPTH));
      check("m_empty", DW'(bus.Empty_out),    DW'(q.size() == 0));
      check("m_pair",  DW'(bus.Pair_avail),   DW'(q.size() >= 2));
      check("m_v1",    DW'(bus.Data_valid_1), DW'(m_v1));
      check("m_v2",    DW'(bus.Data_valid_2), DW'(m_v2));
      check("m_d1",    bus.Data_out_1,        m_d1);
      check("m_d2",    bus.Data_out_2,        m_d2);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.WriteEn_in = 1'b0; bus.ReadEn_in = 1'b0; bus.Drain_in = 1'b0; bus.stall = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] v);
    bus.WriteEn_in = 1'b1; bus.Data_in = v;
    tick();
    bus.WriteEn_in = 1'b0;
  endtask

  task automatic pins(input string nm, input logic v1, input logic v2,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    check({nm, "_v1"}, DW'(bus.Data_valid_1), DW'(v1));
    check({nm, "_v2"}, DW'(bus.Data_valid_2), DW'(v2));
    check({nm, "_d1"}, bus.Data_out_1, d1);
    check({nm, "_d2"}, bus.Data_out_2, d2);
  endtask

  initial begin
    idle();
    bus.Data_in = '0;
    #2 Reset_n = 1'b0;
    #20 Reset_n = 1'b1;
    tick();
    check("rst_empty", DW'(bus.Empty_out), DW'(1));
    check("rst_full",  DW'(bus.Full_out),  DW'(0));
    pins("rst", 1'b0, 1'b0, '0, '0);

    // Fill then two pair reads
    wr(65'hA); wr(65'hB); wr(65'hC); wr(65'hD);
    check("t1_full", DW'(bus.Full_out), DW'(1));
    bus.ReadEn_in = 1'b1;
    tick(); pins("t1_p0", 1'b1, 1'b1, 65'hA, 65'hB);
    tick(); pins("t1_p1", 1'b1, 1'b1, 65'hC, 65'hD);
    idle(); tick();
    pins("t1_idle", 1'b0, 1'b0, 65'hC, 65'hD);
    check("t1_empty", DW'(bus.Empty_out), DW'(1));

    // Write while full is dropped
    wr(65'hA); wr(65'hB); wr(65'hC); wr(65'hD); wr(65'hE);
    check("t2_full", DW'(bus.Full_out), DW'(1));
    bus.ReadEn_in = 1'b1;
    tick(); pins("t2_p0", 1'b1, 1'b1, 65'hA, 65'hB);
    tick(); pins("t2_p1", 1'b1, 1'b1, 65'hC, 65'hD);
    tick(); pins("t2_p2", 1'b0, 1'b0, 65'hC, 65'hD);
    idle();
    check("t2_empty", DW'(bus.Empty_out), DW'(1));

    // Odd entry needs drain
    wr(65'h1); wr(65'h2); wr(65'h3);
    bus.ReadEn_in = 1'b1;
    tick(); pins("t3_pair", 1'b1, 1'b1, 65'h1, 65'h2);
    tick(); pins("t3_nodrain", 1'b0, 1'b0, 65'h1, 65'h2);
    bus.Drain_in = 1'b1;
    tick(); pins("t3_drain", 1'b1, 1'b0, 65'h3, 65'h2);
    idle(); tick();

    // rd_ptr now 3: pair straddles the wrap
    wr(65'h7); wr(65'h8);
    bus.ReadEn_in = 1'b1;
    tick(); pins("t4_wrap", 1'b1, 1'b1, 65'h7, 65'h8);
    idle();

    // Write concurrent with pair pop at count 3, then stall
    wr(65'h11); wr(65'h12); wr(65'h13);
    bus.WriteEn_in = 1'b1; bus.Data_in = 65'h14; bus.ReadEn_in = 1'b1;
    tick(); pins("t5_pop", 1'b1, 1'b1, 65'h11, 65'h12);
    check("t5_pair", DW'(bus.Pair_avail), DW'(1));
    check("t5_full", DW'(bus.Full_out),   DW'(0));
    bus.stall = 1'b1; bus.Data_in = 65'h15;
    for (int i = 0; i < 3; i++) begin
      tick(); pins("t5_stall", 1'b0, 1'b0, 65'h11, 65'h12);
      check("t5_stall_pair", DW'(bus.Pair_avail), DW'(1));
      check("t5_stall_full", DW'(bus.Full_out),   DW'(0));
    end
    bus.stall = 1'b0; bus.WriteEn_in = 1'b0;
    tick(); pins("t5_after", 1'b1, 1'b1, 65'h13, 65'h14);
    idle(); tick();
    check("t5_empty", DW'(bus.Empty_out), DW'(1));

    // Async reset between edges while holding two entries
    wr(65'h21); wr(65'h22);
    check("t6_pair", DW'(bus.Pair_avail), DW'(1));
    #2 Reset_n = 1'b0;
    #1;
    check("t6_empty", DW'(bus.Empty_out),  DW'(1));
    check("t6_pairc", DW'(bus.Pair_avail), DW'(0));
    pins("t6_rst", 1'b0, 1'b0, '0, '0);
    tick(); tick();
    Reset_n = 1'b1;
    bus.ReadEn_in = 1'b1; bus.Drain_in = 1'b1;
    tick(); pins("t6_rel0", 1'b0, 1'b0, '0, '0);
    tick(); pins("t6_rel1", 1'b0, 1'b0, '0, '0);
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fifo_1w_2r.md
Name: fifo_1w_2r

Overview:
- Single-clock FIFO that accepts one entry per cycle on the write side and delivers two entries per cycle on the read side.
- It is the counterpart of the 2-write/1-read FIFO: it regroups a serial stream of DATA_WIDTH words into pairs for dual-lane consumers in the pipeline.
- It has a true occupancy count, real Full_out and Empty_out, a shared stall input, and a drain mode that flushes a trailing odd entry.

Parameters:
- DATA_WIDTH, 65, width of one entry.
- ADDRESS_WIDTH, 2, log2 of the FIFO depth; must be at least 1.
- FIFO_DEPTH, 1<<ADDRESS_WIDTH, number of entries; always a power of two, at least 2.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset_n  input  1  reset; asynchronous assert, active-low.
- stall  input  1  global pipeline stall; freezes both pointers and forces both valids low.
- Data_in  input  DATA_WIDTH  write data.
- WriteEn_in  input  1  write request.
- Full_out  output  1  count == FIFO_DEPTH.
- ReadEn_in  input  1  pair-read request.
- Drain_in  input  1  allows a single-entry pop when only one entry remains.
- Data_out_1  output  DATA_WIDTH  older entry of the popped pair, registered.
- Data_out_2  output  DATA_WIDTH  younger entry of the popped pair, registered.
- Data_valid_1  output  1  Data_out_1 is valid this cycle.
- Data_valid_2  output  1  Data_out_2 is valid this cycle.
- Empty_out  output  1  count == 0.
- Pair_avail  output  1  count >= 2.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - Data_out_1/2 go to 0; Data_valid_1/2 go to 0.
  - Full_out = 0, Empty_out = 1, Pair_avail = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all contents; the first cycle after release behaves like an empty FIFO.
- Pointers:
  - Binary, ADDRESS_WIDTH bits, wrap modulo FIFO_DEPTH.
  - count is ADDRESS_WIDTH+1 bits.
  - Full_out, Empty_out and Pair_avail are combinational decodes of the registered count.
- Write accept:
  - wr_acc = WriteEn_in & !Full_out & !stall.
  - Mem[wr_ptr] <= Data_in; wr_ptr += 1.
  - A write while full, or while stalled, is dropped silently with no state change.
  - There is no same-cycle write-through for a simultaneous pop when full.
- Read accept (evaluated on the registered count, before this cycle's write):
  - pop2 = ReadEn_in & !stall & (count >= 2).
    - Data_out_1 <= Mem[rd_ptr], Data_out_2 <= Mem[rd_ptr+1] (wrapped).
    - Data_valid_1 = Data_valid_2 = 1; rd_ptr += 2.
  - pop1 = ReadEn_in & Drain_in & !stall & (count == 1).
    - Data_out_1 <= Mem[rd_ptr]; Data_valid_1 = 1, Data_valid_2 = 0; rd_ptr += 1.
    - Data_out_2 holds its previous value.
  - Otherwise both valids are 0 next cycle and Data_out_1/2 hold.
  - ReadEn_in with count == 1 and Drain_in = 0 does nothing.
- Latency:
  - Pop data appears one cycle after the accepting edge.
  - A word written at cycle N is poppable from cycle N+1.
- count update: count_next = count + wr_acc − 2·pop2 − pop1.
  - Simultaneous write and pop2 gives a net −1; simultaneous write and pop1 gives a net 0.
  - count never exceeds FIFO_DEPTH and never underflows.
- Wrap-around: the pair read at rd_ptr = FIFO_DEPTH−1 returns Mem[DEPTH−1] on lane 1 and Mem[0] on lane 2.
- Order: entries leave in write order; lane 1 always carries the older entry.
- While stall is high: no pointer or count movement, both valids are 0, and the data outputs hold.

Decomposition:
- Shared package:
  - default DATA_WIDTH/ADDRESS_WIDTH constants, reused by the 2-write/1-read FIFO.
  - a pop-type encoding (NONE, ONE, TWO) used by the count logic and the bench scoreboard.
- One natural sub-module, fifo_rptr_2step: read pointer that advances by 0, 1 or 2 with wrap, outputs rd_ptr and rd_ptr+1.
- The memory array and count logic stay in the top module.

Test Plan (DATA_WIDTH=65, ADDRESS_WIDTH=2):
- Write 0xA,0xB,0xC,0xD on consecutive cycles, then ReadEn_in for two cycles -> Full_out = 1 after the 4th write; outputs (0xA,0xB) then (0xC,0xD) with both valids high; Empty_out = 1 at the end.
- Fill to 4, write 0xE while full -> 0xE is dropped, count stays 4; subsequent pops return A,B,C,D only.
- Write 3 entries (1,2,3) and read a pair -> (1,2); then ReadEn_in=1, Drain_in=0 -> no valid; then Drain_in=1 -> Data_out_1=3, Data_valid_1=1, Data_valid_2=0.
- Wrap: advance the pointers to rd_ptr = 3 and write 7,8 -> pair pop returns (7 from Mem[3], 8 from Mem[0]).
- Simultaneous write and pop2 at count = 3 -> count goes to 2; with stall held high for 3 cycles, count and pointers are unchanged and the valids stay 0.
- Assert Reset_n low between clock edges while count = 2 -> outputs clear immediately; Empty_out = 1; no valid pulses after release.
